video_timing_generator: RTL and testbench

VIDEO_TIMING_GENERATOR -- requirements
Module: video_timing_generator

---
 rtl/video_timing_generator.sv | 118 +++++++++++
 tb/tb_video_timing_generator.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/video_timing_generator.sv
// rtl/video_timing_generator.sv - raster timing generator with registered sync/DE decode and a test pattern
module video_timing_generator #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FRONT  = 88,
    parameter int H_SYNC   = 44,
    parameter int H_TOTAL  = 2200,
    parameter int V_ACTIVE = 1080,
    parameter int V_FRONT  = 4,
    parameter int V_SYNC   = 5,
    parameter int V_TOTAL  = 1125,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic                       I_rgb_clk,
    input  logic                       I_rst,
    input  logic                       I_en,
    output logic                       O_rgb_de,
    output logic                       O_rgb_hs,
    output logic                       O_rgb_vs,
    output logic [$clog2(H_TOTAL)-1:0] O_x,
    output logic [$clog2(V_TOTAL)-1:0] O_y,
    output logic                       O_new_row,
    output logic                       O_new_frame,
    output logic [7:0]                 O_frame_cnt,
    output logic [7:0]                 O_rgb_r,
    output logic [7:0]                 O_rgb_g,
    output logic [7:0]                 O_rgb_b
);

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    // One extra bit so bounds equal to H_TOTAL/V_TOTAL (power of two) still fit.
    localparam logic [HW:0]   H_ACT_E  = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0]   HS_START = (HW+1)'(H_ACTIVE + H_FRONT);
    localparam logic [HW:0]   HS_END   = (HW+1)'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW:0]   V_ACT_E  = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0]   VS_START = (VW+1)'(V_ACTIVE + V_FRONT);
    localparam logic [VW:0]   VS_END   = (VW+1)'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

    generate
        if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_TOTAL < 1 ||
            V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_TOTAL < 1 ||
            H_ACTIVE + H_FRONT + H_SYNC > H_TOTAL ||
            V_ACTIVE + V_FRONT + V_SYNC > V_TOTAL) begin : g_bad_params
            $error("video_timing_generator: inconsistent timing parameters");
        end
    endgenerate

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [7:0]    frame_cnt;
    logic [HW:0]   h_e;
    logic [VW:0]   v_e;
    logic          v_active;
    logic          de_c;
    logic          hs_act;
    logic          vs_act;

    always_comb begin
        h_e      = {1'b0, h};
        v_e      = {1'b0, v};
        v_active = (v_e < V_ACT_E);
        de_c     = (h_e < H_ACT_E) && v_active;
        hs_act   = (h_e >= HS_START) && (h_e < HS_END);
        vs_act   = (v_e >= VS_START) && (v_e < VS_END);
    end

    // Outputs describe the position the counters held before this edge advances them.
    always_ff @(posedge I_rgb_clk) begin
        if (I_rst) begin
            h           <= '0;
            v           <= '0;
            frame_cnt   <= '0;
            O_x         <= '0;
            O_y         <= '0;
            O_rgb_de    <= 1'b0;
            O_rgb_hs    <= ~HS_POL;
            O_rgb_vs    <= ~VS_POL;
            O_new_row   <= 1'b0;
            O_new_frame <= 1'b0;
            O_frame_cnt <= '0;
            O_rgb_r     <= '0;
            O_rgb_g     <= '0;
            O_rgb_b     <= '0;
        end else if (I_en) begin
            if (h == H_LAST) begin
                h <= '0;
                if (v == V_LAST) begin
                    v         <= '0;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    v <= v + 1'b1;
                end
            end else begin
                h <= h + 1'b1;
            end
            O_x         <= h;
            O_y         <= v;
            O_rgb_de    <= de_c;
            O_rgb_hs    <= hs_act ? HS_POL : ~HS_POL;
            O_rgb_vs    <= vs_act ? VS_POL : ~VS_POL;
            O_new_row   <= (h == '0) && v_active;
            O_new_frame <= (h == '0) && (v == '0);
            O_frame_cnt <= frame_cnt;
            O_rgb_r     <= de_c ? 8'(h) : 8'd0;
            O_rgb_g     <= de_c ? 8'(v) : 8'd0;
            O_rgb_b     <= de_c ? frame_cnt : 8'd0;
        end else begin
            // Frozen: levels hold, but single-cycle strobes must not stretch.
            O_new_row   <= 1'b0;
            O_new_frame <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_timing_generator.sv
// tb/tb_video_timing_generator.sv - directed table-driven bench for video_timing_generator
module tb_video_timing_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       de, hs, vs, nr, nf;
    logic [3:0] x, y;
    logic [7:0] fcnt, r, g, b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    video_timing_generator #(
        .H_ACTIVE(4), .H_FRONT(2), .H_SYNC(3), .H_TOTAL(16),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_TOTAL(16),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .I_rgb_clk(clk), .I_rst(rst), .I_en(en),
        .O_rgb_de(de), .O_rgb_hs(hs), .O_rgb_vs(vs),
        .O_x(x), .O_y(y), .O_new_row(nr), .O_new_frame(nf),
        .O_frame_cnt(fcnt), .O_rgb_r(r), .O_rgb_g(g), .O_rgb_b(b)
    );

    typedef struct {
        logic rst, en;
        int   x, y;
        logic de, hs, vs, nr, nf;
        int   r, g;
    } vec_t;

    vec_t tbl[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_nf(output int n);
        n = 0;
        forever begin
            tick();
            n++;
            if (nf === 1'b1 || n >= 300) break;
        end
    endtask

    task automatic wait_pos(input int wx, input int wy);
        int n;
        n = 0;
        while (!(x === 4'(wx) && y === 4'(wy)) && n < 400) begin
            tick();
            n++;
        end
        chk("wait_pos_reached", (n < 400), 1);
    endtask

    initial begin
        int n, c_de, c_hs, c_vs, c_nr, c_nf, c_de_row0, vs_first, vs_last;

        //          rst en  x  y de hs vs nr nf  r  g
        tbl[0]  = '{1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1,  0, 0, 1, 0, 0, 1, 1, 0, 0};
        tbl[3]  = '{0, 1,  1, 0, 1, 0, 0, 0, 0, 1, 0};
        tbl[4]  = '{0, 1,  2, 0, 1, 0, 0, 0, 0, 2, 0};
        tbl[5]  = '{0, 0,  2, 0, 1, 0, 0, 0, 0, 2, 0};
        tbl[6]  = '{0, 0,  2, 0, 1, 0, 0, 0, 0, 2, 0};
        tbl[7]  = '{0, 0,  2, 0, 1, 0, 0, 0, 0, 2, 0};
        tbl[8]  = '{0, 0,  2, 0, 1, 0, 0, 0, 0, 2, 0};
        tbl[9]  = '{0, 0,  2, 0, 1, 0, 0, 0, 0, 2, 0};
        tbl[10] = '{0, 1,  3, 0, 1, 0, 0, 0, 0, 3, 0};
        tbl[11] = '{0, 1,  4, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{0, 1,  5, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[13] = '{0, 1,  6, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[14] = '{0, 1,  7, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[15] = '{0, 1,  8, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[16] = '{0, 1,  9, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[17] = '{0, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[18] = '{0, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[19] = '{0, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[20] = '{0, 1, 13, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[21] = '{0, 1, 14, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[22] = '{0, 1, 15, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[23] = '{0, 1,  0, 1, 1, 0, 0, 1, 0, 0, 1};
        tbl[24] = '{0, 1,  1, 1, 1, 0, 0, 0, 0, 1, 1};

        for (int i = 0; i < 25; i++) begin
            rst = tbl[i].rst;
            en  = tbl[i].en;
            tick();
            chk($sformatf("v%0d_x", i),  x,  tbl[i].x);
            chk($sformatf("v%0d_y", i),  y,  tbl[i].y);
            chk($sformatf("v%0d_de", i), de, tbl[i].de);
            chk($sformatf("v%0d_hs", i), hs, tbl[i].hs);
            chk($sformatf("v%0d_vs", i), vs, tbl[i].vs);
            chk($sformatf("v%0d_nr", i), nr, tbl[i].nr);
            chk($sformatf("v%0d_nf", i), nf, tbl[i].nf);
            chk($sformatf("v%0d_r", i),  r,  tbl[i].r);
            chk($sformatf("v%0d_g", i),  g,  tbl[i].g);
            chk($sformatf("v%0d_b", i),  b,  0);
        end

        // One full frame of counts, starting on the new_frame cycle.
        en = 1'b1;
        wait_nf(n);
        chk("first_frame_nf_found", (nf === 1'b1), 1);
        c_de = 0; c_hs = 0; c_vs = 0; c_nr = 0; c_nf = 0; c_de_row0 = 0;
        vs_first = -1; vs_last = -1;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) tick();
            c_de += int'(de);
            c_hs += int'(hs);
            c_nr += int'(nr);
            c_nf += int'(nf);
            if (de && y == 4'd0) c_de_row0++;
            if (vs) begin
                c_vs++;
                if (vs_first < 0) vs_first = int'(y) * 16 + int'(x);
                vs_last = int'(y) * 16 + int'(x);
            end
        end
        chk("frame_de_cycles", c_de, 16);
        chk("frame_width", c_de_row0, 4);
        chk("frame_height", c_nr, 4);
        chk("frame_hs_cycles", c_hs, 48);
        chk("frame_vs_cycles", c_vs, 32);
        chk("frame_nf_count", c_nf, 1);
        chk("vs_first_pos", vs_first, 5 * 16 + 0);
        chk("vs_last_pos", vs_last, 6 * 16 + 15);
        tick();
        chk("frame_period_nf", nf, 1);

        // Reset in the middle of a sync region.
        wait_pos(7, 5);
        chk("pre_rst_hs", hs, 1);
        chk("pre_rst_vs", vs, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_x", x, 0);
        chk("mid_rst_y", y, 0);
        chk("mid_rst_hs", hs, 0);
        chk("mid_rst_vs", vs, 0);
        chk("mid_rst_de", de, 0);
        chk("mid_rst_nf", nf, 0);
        chk("mid_rst_nr", nr, 0);
        rst = 1'b0;
        tick();
        chk("restart_x", x, 0);
        chk("restart_y", y, 0);
        chk("restart_nf", nf, 1);
        chk("restart_nr", nr, 1);
        chk("restart_de", de, 1);
        chk("restart_fcnt", fcnt, 0);
        tick();
        chk("restart_x1", x, 1);
        chk("restart_nf_clear", nf, 0);

        // 256 frames: counter wraps 255 -> 0 and blue follows it.
        for (int f = 1; f <= 256; f++) begin
            wait_nf(n);
            chk($sformatf("f%0d_period", f), n, (f == 1) ? 255 : 256);
            chk($sformatf("f%0d_fcnt", f), fcnt, f % 256);
            chk($sformatf("f%0d_b", f), b, f % 256);
            if (n >= 300) break;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
